// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester MMU port arbiter:
// FSM state encoding, requester IDs and default port widths.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GNT     = 2'd1,
        ARB_RD_WAIT = 2'd2
    } arb_state_t;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    localparam int ARB_ADDR_W = 15;
    localparam int ARB_DATA_W = 32;

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way combinational pick. With both requests present the requester
// that did not win last time is chosen, unless FIXED_PRIO pins the tie to M0.
module mem_port_arbiter_arb_rr2
    import mem_port_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic       any_req,
    output logic       winner
);

    // Resolve the winner from the request pair and the previous owner
    always_comb begin
        any_req = |req;
        winner  = REQ_M0;
        if (req[0] && req[1]) begin
            winner = FIXED_PRIO ? REQ_M0 : ~rr_last;
        end else if (req[1]) begin
            winner = REQ_M1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single MMU memory port between the CPU datapath (M0) and the
// debug/loader DMA (M1). One access is outstanding at a time: a grant cycle
// puts the latched command on the port, reads then wait RD_LAT cycles and
// return data through the shared m_rdata register with a per-owner rvalid.
// Build option: define MEM_ARB_CPU_PRIO_EN for fixed M0 priority instead of
// round-robin tie breaking.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_sh,
    input  logic              m0_lh,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_sh,
    input  logic              m1_lh,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_sh,
    output logic              mem_lh,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int               LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;

    logic              cmd_we;
    logic              cmd_sh;
    logic              cmd_lh;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              owner;
    logic              rvalid_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic              lat_done;

    logic              any_req;
    logic              winner;
    logic              rr_last;
    logic              accept;

    assign lat_done = (lat_cnt == LAT_LAST);
    assign accept   = (state == ARB_IDLE) && any_req;

`ifdef MEM_ARB_CPU_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;

    assign rr_last = REQ_M1;
`else
    localparam bit FIXED_PRIO = 1'b0;

    // Remember who won the last arbitration so the other side wins the next tie
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= REQ_M1;
        end else if (accept) begin
            rr_last <= winner;
        end
    end
`endif

    mem_port_arbiter_arb_rr2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb_rr2 (
        .req     ({m1_req, m0_req}),
        .rr_last (rr_last),
        .any_req (any_req),
        .winner  (winner)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; any unused encoding falls back to IDLE
    always_comb begin
        state_nxt = ARB_IDLE;
        case (state)
            ARB_IDLE:    state_nxt = any_req ? ARB_GNT : ARB_IDLE;
            ARB_GNT:     state_nxt = cmd_we ? ARB_IDLE : ARB_RD_WAIT;
            ARB_RD_WAIT: state_nxt = lat_done ? ARB_IDLE : ARB_RD_WAIT;
            default:     state_nxt = ARB_IDLE;
        endcase
    end

    // Command latch, read latency counter and read data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_we    <= 1'b0;
            cmd_sh    <= 1'b0;
            cmd_lh    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            owner     <= REQ_M0;
            lat_cnt   <= '0;
            rvalid_q  <= 1'b0;
            m_rdata   <= '0;
        end else begin
            rvalid_q <= 1'b0;
            if (accept) begin
                owner <= winner;
                if (winner == REQ_M1) begin
                    cmd_we    <= m1_we;
                    cmd_sh    <= m1_sh;
                    cmd_lh    <= m1_lh;
                    cmd_addr  <= m1_addr;
                    cmd_wdata <= m1_wdata;
                end else begin
                    cmd_we    <= m0_we;
                    cmd_sh    <= m0_sh;
                    cmd_lh    <= m0_lh;
                    cmd_addr  <= m0_addr;
                    cmd_wdata <= m0_wdata;
                end
            end
            if (state == ARB_GNT) begin
                lat_cnt <= '0;
            end else if (state == ARB_RD_WAIT) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end
            if ((state == ARB_RD_WAIT) && lat_done) begin
                m_rdata  <= mem_rdata;
                rvalid_q <= 1'b1;
            end
        end
    end

    // Grant, write strobe and busy decode from the current state
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        mem_we = 1'b0;
        busy   = 1'b0;
        case (state)
            ARB_GNT: begin
                busy   = 1'b1;
                mem_we = cmd_we;
                m0_gnt = (owner == REQ_M0);
                m1_gnt = (owner == REQ_M1);
            end
            ARB_RD_WAIT: busy = 1'b1;
            default: ;
        endcase
        m0_rvalid = rvalid_q && (owner == REQ_M0);
        m1_rvalid = rvalid_q && (owner == REQ_M1);
    end

    // Address and qualifiers stay on the port until the next accepted command
    assign mem_addr  = cmd_addr;
    assign mem_sh    = cmd_sh;
    assign mem_lh    = cmd_lh;
    assign mem_wdata = cmd_wdata;

endmodule
